// File: rtl/reg_hazard_pkg.sv
// -----------------------------------------------------------------------------
// reg_hazard_pkg
// Shared types and constants for the register hazard / forwarding controller.
//   fwd_sel_t    : EX operand source select (register file, MEM result, WB result)
//   slot_t       : per-stage scoreboard entry {valid, rd, regwrite, memread}
//   slot_writing : true when a slot will really update the register file
// -----------------------------------------------------------------------------
package reg_hazard_pkg;

  localparam int REG_AW_P         = 5;   // register address width
  localparam int ZERO_REG_DEFAULT = 31;  // hardwired-zero register index

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic                valid;
    logic [REG_AW_P-1:0] rd;
    logic                regwrite;
    logic                memread;
  } slot_t;

  localparam slot_t SLOT_BUBBLE = '0;

  // A slot only counts as a producer if it is real, writes, and does not target
  // the zero register (writes to the zero register are discarded anyway).
  function automatic logic slot_writing(input slot_t               s,
                                        input logic [REG_AW_P-1:0] zero_idx);
    return s.valid && s.regwrite && (s.rd != zero_idx);
  endfunction

endpackage

// File: rtl/reg_hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// reg_hazard_ctrl_if
// Bundle between the pipeline (master) and the hazard controller (slave).
//   master drives : id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd,
//                   id_regwrite, id_memread, flush
//   slave drives  : stall, ex_fwd_a, ex_fwd_b, wb_rd, wb_we
// -----------------------------------------------------------------------------
interface reg_hazard_ctrl_if;

  logic                                 id_valid;
  logic [reg_hazard_pkg::REG_AW_P-1:0]  id_rn;
  logic [reg_hazard_pkg::REG_AW_P-1:0]  id_rm;
  logic                                 id_use_rn;
  logic                                 id_use_rm;
  logic [reg_hazard_pkg::REG_AW_P-1:0]  id_rd;
  logic                                 id_regwrite;
  logic                                 id_memread;
  logic                                 flush;

  logic                                 stall;
  logic [1:0]                           ex_fwd_a;
  logic [1:0]                           ex_fwd_b;
  logic [reg_hazard_pkg::REG_AW_P-1:0]  wb_rd;
  logic                                 wb_we;

  modport master (
    output id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd,
           id_regwrite, id_memread, flush,
    input  stall, ex_fwd_a, ex_fwd_b, wb_rd, wb_we
  );

  modport slave (
    input  id_valid, id_rn, id_rm, id_use_rn, id_use_rm, id_rd,
           id_regwrite, id_memread, flush,
    output stall, ex_fwd_a, ex_fwd_b, wb_rd, wb_we
  );

endinterface

// File: rtl/hazard_slot_cmp.sv
// -----------------------------------------------------------------------------
// hazard_slot_cmp
// Compares one scoreboard slot against one ID source operand.
//   slot    in  : scoreboard entry of an in-flight stage
//   src     in  : source register index read in ID
//   use_src in  : the source is actually read
//   match   out : slot is writing and its rd equals src (zero register excluded)
// -----------------------------------------------------------------------------
module hazard_slot_cmp
  import reg_hazard_pkg::*;
#(
  parameter logic [REG_AW_P-1:0] ZERO_IDX = REG_AW_P'(ZERO_REG_DEFAULT)
) (
  input  slot_t               slot,
  input  logic [REG_AW_P-1:0] src,
  input  logic                use_src,
  output logic                match
);

  assign match = use_src && (src != ZERO_IDX) &&
                 slot_writing(slot, ZERO_IDX) && (slot.rd == src);

endmodule

// File: rtl/reg_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// reg_hazard_ctrl
// Scoreboard hazard / forwarding controller for a five-stage pipeline with a
// 32 x 64-bit register file whose ZERO_REG entry is hardwired to zero.
// Tracks the destination of the instructions in EX, MEM and WB, raises a
// combinational load-use stall for ID, registers the EX operand forward
// selects, and squashes in-flight writes on a branch flush.
//
// Ports
//   clk          in  : pipeline clock, rising-edge
//   reset        in  : asynchronous, active-high
//   bus          if  : reg_hazard_ctrl_if.slave (ID inputs, flush, stall,
//                      ex_fwd_a/b, wb_rd, wb_we)
//   stall_count  out : saturating stall-cycle counter, present only when
//                      HAZARD_STATS_EN is defined
//
// Build option
//   HAZARD_STATS_EN : adds the stall_count port and its counter.
// -----------------------------------------------------------------------------
module reg_hazard_ctrl
  import reg_hazard_pkg::*;
#(
  parameter int REG_AW   = REG_AW_P,
  parameter int ZERO_REG = ZERO_REG_DEFAULT,
  parameter int CNT_W    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  reg_hazard_ctrl_if.slave      bus
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]      stall_count
`endif
);

  localparam logic [REG_AW-1:0] ZERO_IDX = REG_AW'(ZERO_REG);

  // Scoreboard slots and registered forward selects
  slot_t    ex_q,    ex_d;
  slot_t    mem_q,   mem_d;
  slot_t    wb_q,    wb_d;
  fwd_sel_t fwd_a_q, fwd_a_d;
  fwd_sel_t fwd_b_q, fwd_b_d;

  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b;
  logic stall_int;
  logic bubble;

  // Source x stage comparators (WB never forwards: the regfile write and the
  // ID read of the same cycle are resolved inside the register file).
  hazard_slot_cmp #(.ZERO_IDX(ZERO_IDX)) u_cmp_ex_a (
    .slot(ex_q),  .src(bus.id_rn), .use_src(bus.id_use_rn), .match(ex_hit_a));
  hazard_slot_cmp #(.ZERO_IDX(ZERO_IDX)) u_cmp_ex_b (
    .slot(ex_q),  .src(bus.id_rm), .use_src(bus.id_use_rm), .match(ex_hit_b));
  hazard_slot_cmp #(.ZERO_IDX(ZERO_IDX)) u_cmp_mem_a (
    .slot(mem_q), .src(bus.id_rn), .use_src(bus.id_use_rn), .match(mem_hit_a));
  hazard_slot_cmp #(.ZERO_IDX(ZERO_IDX)) u_cmp_mem_b (
    .slot(mem_q), .src(bus.id_rm), .use_src(bus.id_use_rm), .match(mem_hit_b));

  // Nearer stage wins. A load in EX cannot forward yet (its data appears at the
  // end of MEM); that case is covered by the stall, after which the load sits
  // in MEM and the consumer picks it up from WB.
  function automatic fwd_sel_t fwd_pick(input logic hit_ex,
                                        input logic hit_mem,
                                        input logic ex_is_load);
    if (hit_ex && !ex_is_load) return FWD_MEM;
    if (hit_mem)               return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path through
    // the block leaves a value unassigned and no latch is inferred.
    ex_d    = SLOT_BUBBLE;
    mem_d   = ex_q;
    wb_d    = mem_q;
    fwd_a_d = FWD_RF;
    fwd_b_d = FWD_RF;

    // flush overrides stall: the consumer is squashed, so it cannot stall.
    stall_int = bus.id_valid && !bus.flush && ex_q.memread &&
                (ex_hit_a || ex_hit_b);

    // An invalid ID instruction enters EX as a bubble as well.
    bubble = stall_int || bus.flush || !bus.id_valid;

    if (!bubble) begin
      ex_d = '{valid:    1'b1,
               rd:       bus.id_rd,
               regwrite: bus.id_regwrite,
               memread:  bus.id_memread};
      fwd_a_d = fwd_pick(ex_hit_a, mem_hit_a, ex_q.memread);
      fwd_b_d = fwd_pick(ex_hit_b, mem_hit_b, ex_q.memread);
    end

    // Flush squashes the instruction leaving EX; MEM -> WB always proceeds.
    if (bus.flush) mem_d = SLOT_BUBBLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_q    <= SLOT_BUBBLE;
      mem_q   <= SLOT_BUBBLE;
      wb_q    <= SLOT_BUBBLE;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
    end
  end

  assign bus.stall    = stall_int;
  assign bus.ex_fwd_a = fwd_a_q;
  assign bus.ex_fwd_b = fwd_b_q;
  assign bus.wb_rd    = wb_q.rd;
  assign bus.wb_we    = slot_writing(wb_q, ZERO_IDX);

`ifdef HAZARD_STATS_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturates at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (stall_int && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign stall_count = cnt_q;
`endif

endmodule

// File: tb/tb_reg_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_reg_hazard_ctrl
// Directed scenarios followed by random traffic for reg_hazard_ctrl. Expected
// values come from a reference model that views the pipeline as a list of
// in-flight instructions and asks "which is the nearest older writer of this
// register". Compile with +define+HAZARD_STATS_EN to also check stall_count.
// -----------------------------------------------------------------------------
module tb_reg_hazard_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_hazard_ctrl_if bus ();

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_count;
  int unsigned exp_cnt = 0;
`endif

  reg_hazard_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef HAZARD_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  // In-flight instruction list: index 0 = EX, 1 = MEM, 2 = WB.
  typedef struct {
    bit v;
    int rd;
    bit rw;
    bit ld;
  } instr_t;

  instr_t pipe [3];
  bit     obs_stall;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic instr_t empty_instr();
    instr_t e;
    e = '{v: 1'b0, rd: 0, rw: 1'b0, ld: 1'b0};
    return e;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) pipe[i] = empty_instr();
  endtask

  function automatic bit writes(input instr_t i);
    return i.v && i.rw && (i.rd != 31);
  endfunction

  // Distance (1 = EX, 2 = MEM) of the nearest older instruction writing r.
  function automatic int producer_dist(input int r);
    for (int i = 0; i < 2; i++)
      if (writes(pipe[i]) && pipe[i].rd == r) return i + 1;
    return 0;
  endfunction

  function automatic bit load_use(input int r, input bit u);
    return u && (r != 31) && (producer_dist(r) == 1) && pipe[0].ld;
  endfunction

  function automatic int exp_sel(input int r, input bit u);
    int d;
    if (!u || r == 31) return 0;
    d = producer_dist(r);
    if (d == 1) return pipe[0].ld ? 0 : 1;
    if (d == 2) return 2;
    return 0;
  endfunction

  task automatic drive(input bit v, input int rn, input bit urn, input int rm,
                       input bit urm, input int rd, input bit rw, input bit ld,
                       input bit fl);
    bus.id_valid    = v;
    bus.id_rn       = 5'(rn);
    bus.id_use_rn   = urn;
    bus.id_rm       = 5'(rm);
    bus.id_use_rm   = urm;
    bus.id_rd       = 5'(rd);
    bus.id_regwrite = rw;
    bus.id_memread  = ld;
    bus.flush       = fl;
  endtask

  // One pipeline cycle: drive ID at the falling edge, check stall mid-cycle,
  // advance the model at the rising edge, check registered outputs just after.
  task automatic cyc(input bit v, input int rn, input bit urn, input int rm,
                     input bit urm, input int rd, input bit rw, input bit ld,
                     input bit fl);
    bit     e_stall, bub;
    int     ea, eb;
    instr_t nw;
    @(negedge clk);
    drive(v, rn, urn, rm, urm, rd, rw, ld, fl);
    #1;
    e_stall   = v && !fl && (load_use(rn, urn) || load_use(rm, urm));
    obs_stall = bus.stall;
    check("stall", 32'(bus.stall), 32'(e_stall));
    bub = e_stall || fl || !v;
    ea  = bub ? 0 : exp_sel(rn, urn);
    eb  = bub ? 0 : exp_sel(rm, urm);
    nw  = bub ? empty_instr() : '{v: 1'b1, rd: rd, rw: rw, ld: ld};
    @(posedge clk);
    pipe[2] = pipe[1];
    pipe[1] = fl ? empty_instr() : pipe[0];
    pipe[0] = nw;
`ifdef HAZARD_STATS_EN
    if (e_stall) exp_cnt++;
`endif
    #1;
    check("ex_fwd_a", 32'(bus.ex_fwd_a), 32'(ea));
    check("ex_fwd_b", 32'(bus.ex_fwd_b), 32'(eb));
    check("wb_we", 32'(bus.wb_we), 32'(writes(pipe[2])));
    if (writes(pipe[2])) check("wb_rd", 32'(bus.wb_rd), 32'(pipe[2].rd));
`ifdef HAZARD_STATS_EN
    check("stall_count", stall_count, exp_cnt);
`endif
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  function automatic int rand_reg();
    int r;
    r = int'($urandom_range(0, 8));
    return (r == 8) ? 31 : r;
  endfunction

  initial begin
    // ---------------- reset state ----------------
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    #12;
    check("rst_stall", 32'(bus.stall), 0);
    check("rst_wb_we", 32'(bus.wb_we), 0);
    check("rst_wb_rd", 32'(bus.wb_rd), 0);
    check("rst_fwd_a", 32'(bus.ex_fwd_a), 0);
    check("rst_fwd_b", 32'(bus.ex_fwd_b), 0);
`ifdef HAZARD_STATS_EN
    check("rst_stall_count", stall_count, 0);
`endif
    @(negedge clk);
    reset = 1'b0;

    // ---------------- load-use: LDR X3 ; ADD reads X3 ----------------
    cyc(1, 0, 0, 0, 0, 3, 1, 1, 0);
    cyc(1, 3, 1, 4, 1, 8, 1, 0, 0);
    check("lu_stall_first", 32'(obs_stall), 1);
    check("lu_bubble_fwd_a", 32'(bus.ex_fwd_a), 0);
    cyc(1, 3, 1, 4, 1, 8, 1, 0, 0);
    check("lu_stall_second", 32'(obs_stall), 0);
    check("lu_fwd_a_wb", 32'(bus.ex_fwd_a), 2);

    // ---------------- ALU back-to-back on both sources ----------------
    cyc(1, 0, 0, 0, 0, 5, 1, 0, 0);
    cyc(1, 5, 1, 5, 1, 6, 1, 0, 0);
    check("alu_no_stall", 32'(obs_stall), 0);
    check("alu_fwd_a", 32'(bus.ex_fwd_a), 1);
    check("alu_fwd_b", 32'(bus.ex_fwd_b), 1);

    // ---------------- double match: nearest wins, then MEM only ----------------
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 0);
    cyc(1, 7, 1, 0, 0, 12, 1, 0, 0);
    check("dbl_fwd_a_nearest", 32'(bus.ex_fwd_a), 1);
    cyc(1, 0, 0, 0, 0, 7, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 9, 1, 0, 0);
    cyc(1, 7, 1, 0, 0, 12, 1, 0, 0);
    check("mem_only_fwd_a", 32'(bus.ex_fwd_a), 2);

    // ---------------- zero register ----------------
    cyc(1, 0, 0, 0, 0, 31, 1, 1, 0);
    cyc(1, 31, 1, 31, 1, 13, 1, 0, 0);
    check("zero_no_stall", 32'(obs_stall), 0);
    check("zero_fwd_a", 32'(bus.ex_fwd_a), 0);
    idle();
    check("zero_wb_we", 32'(bus.wb_we), 0);

    // ---------------- flush during load-use ----------------
    cyc(1, 0, 0, 0, 0, 3, 1, 1, 0);
    cyc(1, 3, 1, 0, 0, 8, 1, 0, 1);
    check("flush_no_stall", 32'(obs_stall), 0);
    check("flush_fwd_a", 32'(bus.ex_fwd_a), 0);
    idle();
    check("flush_wb_we", 32'(bus.wb_we), 0);

    // ---------------- async reset mid-stall ----------------
    cyc(1, 0, 0, 0, 0, 10, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 11, 1, 0, 0);
    cyc(1, 11, 1, 0, 0, 3, 1, 1, 0);
    @(negedge clk);
    drive(1, 3, 1, 0, 0, 8, 1, 0, 0);
    #1;
    check("pre_rst_stall", 32'(bus.stall), 1);
    check("pre_rst_wb_we", 32'(bus.wb_we), 1);
    check("pre_rst_fwd_a", 32'(bus.ex_fwd_a), 1);
    #1;
    reset = 1'b1;
    #1;
    check("mid_rst_stall", 32'(bus.stall), 0);
    check("mid_rst_wb_we", 32'(bus.wb_we), 0);
    check("mid_rst_fwd_a", 32'(bus.ex_fwd_a), 0);
    check("mid_rst_fwd_b", 32'(bus.ex_fwd_b), 0);
`ifdef HAZARD_STATS_EN
    check("mid_rst_stall_count", stall_count, 0);
    exp_cnt = 0;
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;

    // First instruction after reset reads the register the lost load targeted.
    cyc(1, 3, 1, 3, 1, 4, 1, 0, 0);
    check("post_rst_fwd_a", 32'(bus.ex_fwd_a), 0);
    check("post_rst_fwd_b", 32'(bus.ex_fwd_b), 0);

    // Three forced load-use stalls.
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0, 0, 3, 1, 1, 0);
      cyc(1, 0, 0, 3, 1, 6, 1, 0, 0);
      cyc(1, 0, 0, 3, 1, 6, 1, 0, 0);
    end
`ifdef HAZARD_STATS_EN
    check("three_stalls_count", stall_count, 3);
`endif

    // ---------------- random traffic against the model ----------------
    for (int n = 0; n < 400; n++) begin
      bit v, urn, urm, rw, ld, fl;
      int rn, rm, rd;
      v   = ($urandom_range(0, 9) != 0);
      rn  = rand_reg();
      rm  = rand_reg();
      rd  = rand_reg();
      urn = ($urandom_range(0, 3) != 0);
      urm = ($urandom_range(0, 3) != 0);
      rw  = ($urandom_range(0, 4) != 0);
      ld  = rw && ($urandom_range(0, 2) == 0);
      fl  = ($urandom_range(0, 11) == 0);
      cyc(v, rn, urn, rm, urm, rd, rw, ld, fl);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/reg_hazard_ctrl.md
# reg_hazard_ctrl

Scoreboard-based hazard and forwarding controller for the 32-entry, 64-bit register file (X31 hardwired to zero) in the five-stage pipeline. It tracks the destination register of every in-flight instruction in EX, MEM and WB. From that state it decides whether the instruction in ID must stall (load-use). It also produces registered operand-forwarding selects for the EX stage, and squashes in-flight writes on a branch flush.

## Interface
Parameters:
- REG_AW, 5, register address width
- ZERO_REG, 31, register index that never creates a hazard
- CNT_W, 32, width of the stall counter (only used with the stats macro)

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rn, id_rm  in  REG_AW  source registers of the ID instruction
- id_use_rn, id_use_rm  in  1  corresponding source is actually read
- id_rd  in  REG_AW  destination of the ID instruction
- id_regwrite  in  1  ID instruction writes id_rd
- id_memread  in  1  ID instruction is a load
- flush  in  1  branch taken; squash ID and EX
- stall  out  1  hold PC and IF/ID; insert bubble into EX (combinational)
- ex_fwd_a, ex_fwd_b  out  2  registered operand selects for EX: 00 regfile, 01 MEM-stage result, 10 WB-stage result
- wb_rd  out  REG_AW  destination held in the WB slot
- wb_we  out  1  WB slot writes the register file
- stall_count  out  CNT_W  saturating count of stall cycles (only with HAZARD_STATS_EN)

## Operation
- Three slots: EX, MEM, WB. Each slot holds {valid, rd, regwrite, memread}.
- A slot is "writing" when valid && regwrite && rd != ZERO_REG.
- Each cycle the slots shift: MEM→WB and EX→MEM. The ID instruction enters EX unless stall or flush is asserted, in which case a bubble (valid=0) enters.
- flush also turns the EX slot into a bubble as it moves to MEM. MEM→WB is never squashed.
- stall = id_valid && !flush && the EX slot is a writing load && its rd matches a used source (id_rn with id_use_rn, or id_rm with id_use_rm). ZERO_REG sources never match.
- Forward select for each source is computed in ID and registered into ex_fwd_* on an accepted (non-stall, non-flush) edge:
  - 01 if the EX slot is writing, is not a load, and its rd matches the source.
  - else 10 if the MEM slot is writing and its rd matches the source.
  - else 00.
- Nearer stage wins: if both match, the select is 01.
- A load in MEM matching the source selects 10. This is the post-stall case, where the load has reached WB when the consumer reaches EX.
- On a bubble entry (stall or flush), ex_fwd_a and ex_fwd_b become 00.
- Unused sources (use=0) always select 00.
- wb_rd and wb_we come directly from the WB slot; wb_we is the slot's writing predicate. The register file write for ZERO_REG is therefore suppressed here as well.

## Timing
- Reset (asynchronous): all slots invalid, ex_fwd_a/b=00, wb_we=0, wb_rd=0, stall_count=0. stall is 0 while reset is held because slots are invalid.
- stall has zero latency (combinational from slot state and ID inputs). Load-use costs exactly one stall cycle. On the next cycle the load sits in MEM, stall drops, and the consumer's select resolves to 10.
- Forwarding selects and slot state have one-cycle latency.
- flush and stall in the same cycle: flush wins, stall=0, and one bubble is inserted.
- A reset mid-stall drops all pending hazards immediately. The first instruction after reset sees no forwarding.

## Configuration
- HAZARD_STATS_EN defined: stall_count increments on every cycle where stall=1 and saturates at all-ones.
- HAZARD_STATS_EN undefined: the stall_count port is absent and no counter logic is built.

## Structure
- Package reg_hazard_pkg holds:
  - the fwd_sel_t enum (FWD_RF=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10)
  - the slot_t struct {valid, rd, regwrite, memread}
  - the ZERO_REG default constant
- Sub-module hazard_slot_cmp: given a slot_t and a source register with its use bit, returns match (writing and equal, non-zero).
  - Instantiated for each source × stage pair.

## Test plan
- Load-use: load X3 in EX, ID add reads X3 with use=1 → stall=1 for exactly one cycle, then ex_fwd_a=10 on the consumer's EX cycle.
- ALU back-to-back: ADD X5 followed by SUB reading X5 on both rm and rn → no stall; ex_fwd_a=01 and ex_fwd_b=01.
- Double match: X7 written in EX and also in MEM, ID reads X7 → ex_fwd_a=01 (nearest wins). With only the MEM slot matching → 10.
- Zero register: load X31 in EX, ID reads X31 → stall=0, ex_fwd_a=00, wb_we=0 when the load reaches WB.
- Flush during load-use: same setup as the first case plus flush=1 → stall=0; EX and ID become bubbles; wb_we=0 two cycles later.
- Async reset mid-stall: assert reset between clock edges while stall=1 → stall, wb_we and ex_fwd_* go to 0 immediately. With HAZARD_STATS_EN, stall_count=0 after reset and equals 3 after three forced load-use stalls.
